// File: rtl/banked_memory_bus.sv
// banked_memory_bus: registered CPU bus router with per-bank wait states, write protection and a watchdog
module banked_memory_bus #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int BANK_BITS = 2,
    parameter int BANK_LSB = 13,
    parameter logic [4*(2**BANK_BITS)-1:0] BANK_WAIT = '0,
    parameter logic [(2**BANK_BITS)-1:0] READ_ONLY_MASK = 'b0010,
    parameter int TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              address,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               bus_enable,
    input  logic                               write_enable,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               ready,
    output logic                               bus_error,
    output logic [ADDR_WIDTH-1:0]              bank_address,
    output logic [DATA_WIDTH-1:0]              bank_wdata,
    output logic [(2**BANK_BITS)-1:0]          bank_select,
    output logic                               bank_write_enable,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0] bank_rdata,
    input  logic [(2**BANK_BITS)-1:0]          bank_ready
);
    localparam int NUM_BANKS = 2**BANK_BITS;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [NUM_BANKS-1:0] ONE = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t                  state_q;
    logic [BANK_BITS-1:0]    bank_q;
    logic                    we_q;
    logic [3:0]              wait_q;
    logic [TW-1:0]           tmo_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    ready_q;
    logic                    bus_error_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_BANKS-1:0]    sel_q;
    logic                    bwe_q;

    logic [BANK_BITS-1:0]    req_bank;
    logic [3:0]              req_wait;
    logic                    req_prot;
    logic                    cur_prot;
    logic                    cur_ready;
    logic                    tmo_hit;
    logic [DATA_WIDTH-1:0]   cur_rdata;

    // Decode the incoming request and the latched transaction's bank
    always_comb begin
        req_bank  = address[BANK_LSB +: BANK_BITS];
        req_wait  = BANK_WAIT[4*req_bank +: 4];
        req_prot  = write_enable & READ_ONLY_MASK[req_bank];
        cur_prot  = we_q & READ_ONLY_MASK[bank_q];
        cur_ready = bank_ready[bank_q];
        cur_rdata = bank_rdata[bank_q*DATA_WIDTH +: DATA_WIDTH];
        tmo_hit   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));
    end

    // Transaction FSM; every output is a register written here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            tmo_q       <= '0;
            data_out_q  <= '0;
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            bwe_q       <= 1'b0;
        end else begin
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: if (bus_enable) begin
                    addr_q  <= address;
                    wdata_q <= data_in;
                    we_q    <= write_enable;
                    bank_q  <= req_bank;
                    wait_q  <= req_wait;
                    tmo_q   <= TW'(1);
                    state_q <= (req_wait != 4'd0) ? WAIT : ACCESS;
                    sel_q   <= (req_wait == 4'd0 && !req_prot) ? (ONE << req_bank) : '0;
                    bwe_q   <= (req_wait == 4'd0) && write_enable && !req_prot;
                end
                WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        state_q <= ACCESS;
                        sel_q   <= cur_prot ? '0 : (ONE << bank_q);
                        bwe_q   <= we_q && !cur_prot;
                    end
                end
                ACCESS: if (cur_prot || cur_ready || tmo_hit) begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                    sel_q   <= '0;
                    bwe_q   <= 1'b0;
                    if (!cur_prot && cur_ready && !we_q)
                        data_out_q <= cur_rdata;
                    else if (!cur_prot && !cur_ready) begin
                        data_out_q  <= '1;
                        bus_error_q <= 1'b1;
                    end
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out          = data_out_q;
    assign ready             = ready_q;
    assign bus_error         = bus_error_q;
    assign bank_address      = addr_q;
    assign bank_wdata        = wdata_q;
    assign bank_select       = sel_q;
    assign bank_write_enable = bwe_q;
endmodule

// File: tb/tb_banked_memory_bus.sv
// tb_banked_memory_bus: directed and randomized transactions checked against a latency/data model
module tb_banked_memory_bus;
    localparam int TMO = 8;
    localparam logic [15:0] WAITS_P = 16'h0300;
    localparam logic [3:0] RO_P = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = '0;
    logic [15:0] data_in = '0;
    logic        bus_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [15:0] data_out;
    logic        ready;
    logic        bus_error;
    logic [15:0] bank_address;
    logic [15:0] bank_wdata;
    logic [3:0]  bank_select;
    logic        bank_write_enable;
    logic [63:0] bank_rdata = '0;
    logic [3:0]  bank_ready = '0;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_data = '0;
    int waits [4] = '{0, 0, 3, 0};
    bit ro [4] = '{0, 1, 0, 0};

    banked_memory_bus #(
        .BANK_WAIT(WAITS_P),
        .READ_ONLY_MASK(RO_P),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .data_in(data_in),
        .bus_enable(bus_enable),
        .write_enable(write_enable),
        .data_out(data_out),
        .ready(ready),
        .bus_error(bus_error),
        .bank_address(bank_address),
        .bank_wdata(bank_wdata),
        .bank_select(bank_select),
        .bank_write_enable(bank_write_enable),
        .bank_rdata(bank_rdata),
        .bank_ready(bank_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic [15:0] a, input logic w, input logic [15:0] wd, input int low,
                        input bit hold, input bit pulse, input logic [15:0] rdv);
        int b, wt, exp_sel, exp_lat, lat, sel_n, bad;
        bit prot, tmo;
        logic [15:0] got_data;
        logic got_err;
        logic [3:0] got_sel;
        b = int'(a[14:13]);
        wt = waits[b];
        prot = w && ro[b];
        tmo = !prot && low >= TMO;
        exp_sel = prot ? 0 : (tmo ? TMO : low + 1);
        exp_lat = 1 + wt + (prot ? 1 : exp_sel);
        bank_rdata = {$urandom, $urandom};
        bank_rdata[b*16 +: 16] = rdv;
        address = a;
        data_in = wd;
        write_enable = w;
        bus_enable = 1'b1;
        lat = 0;
        sel_n = 0;
        bad = 0;
        got_data = '0;
        got_err = 1'b0;
        got_sel = '0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            bus_enable = hold;
            if (ready) begin
                lat = c;
                got_data = data_out;
                got_err = bus_error;
                got_sel = bank_select;
            end else if (bank_select != 4'd0) begin
                sel_n++;
                if (pulse && sel_n == 1) bus_enable = 1'b1;
                if (bank_select !== (4'b0001 << b) || bank_write_enable !== w ||
                    bank_address !== a || bank_wdata !== wd) bad++;
            end else if (bank_write_enable !== 1'b0) bad++;
            bank_ready = 4'($urandom);
            bank_ready[b] = !prot && (sel_n > low);
        end
        bus_enable = 1'b0;
        if (!prot && !tmo && !w) exp_data = rdv;
        if (tmo) exp_data = 16'hFFFF;
        chk("latency", lat, exp_lat);
        chk("select_cycles", sel_n, exp_sel);
        chk("strobe_consistency", bad, 0);
        chk("select_low_at_ready", got_sel, 0);
        chk("data_out", got_data, exp_data);
        chk("bus_error", got_err, tmo);
        @(negedge clk);
        chk("ready_one_cycle", {ready, bus_error}, 0);
        chk("data_out_held", data_out, exp_data);
    endtask

    initial begin
        int saw;
        repeat (2) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_ready", {ready, bus_error}, 0);
        chk("rst_strobes", {bank_select, bank_write_enable}, 0);
        chk("rst_addr_wdata", {bank_address, bank_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        xact(16'h0010, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h1234);
        xact(16'h6005, 1'b1, 16'hBEEF, 0, 1'b0, 1'b0, 16'($urandom));
        xact(16'h2000, 1'b1, 16'h5555, 0, 1'b0, 1'b0, 16'($urandom));
        xact(16'h4000, 1'b0, 16'h0000, 2, 1'b0, 1'b0, 16'h00AA);
        xact(16'h0100, 1'b0, 16'h0000, 100, 1'b0, 1'b0, 16'h7777);
        xact(16'h6002, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 16'h3C3C);
        xact(16'h6000, 1'b0, 16'h0000, 3, 1'b0, 1'b1, 16'h5A5A);
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready || bank_select != 4'd0) saw++;
        end
        chk("no_second_xact", saw, 0);

        address = 16'h4000;
        write_enable = 1'b0;
        bus_enable = 1'b1;
        @(negedge clk);
        bus_enable = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_data_out", data_out, 0);
        chk("midreset_ready", {ready, bus_error}, 0);
        chk("midreset_strobes", {bank_select, bank_write_enable}, 0);
        chk("midreset_addr_wdata", {bank_address, bank_wdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_data = '0;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready || bank_select != 4'd0) saw++;
        end
        chk("no_ready_after_reset", saw, 0);

        for (int i = 0; i < 40; i++)
            xact(16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
                 1'($urandom), 1'b0, 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
